// File: rtl/ft60x_bfm_pkg.sv
// ft60x_bfm_pkg
//   Shared definitions for the FT60x synchronous-FIFO bus functional model:
//   bus FSM state encoding, proto_err bit positions, LFSR tap mask and a
//   constant-safe clog2 helper.
package ft60x_bfm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } bus_state_t;

    localparam int ERR_OE_WR       = 0;  // oe_n and wr_n low together
    localparam int ERR_RD_OUTSIDE  = 1;  // rd_n low while not in RD
    localparam int ERR_WR_NO_SPACE = 2;  // wr_n low while channel's txe_n high
    localparam int ERR_CH_CHANGE   = 3;  // channel select moved mid-transfer

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ft60x_fwft_fifo.sv
// ft60x_fwft_fifo
//   First-word-fall-through FIFO: a RAM-style array plus a registered head
//   word. A word pushed at edge N is counted in level after N and reaches the
//   head (head_valid) after edge N+1. Push and pop in the same cycle are both
//   honoured. level counts every stored word, head included.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request/data (ignored while full)
//   pop                consume head (ignored while head_valid is low)
//   head_valid/_data   current head word
//   level              occupancy, 0..DEPTH
//   full               level == DEPTH
module ft60x_fwft_fifo
    import ft60x_bfm_pkg::*;
#(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    mem_cnt;
    logic             push_eff;
    logic             pop_eff;
    logic             load;

    always_comb begin
        full     = (level == LW'(DEPTH));
        mem_cnt  = level - LW'(head_valid);
        push_eff = push && !full;
        pop_eff  = pop && head_valid;
        // refill the head whenever it is empty or being consumed this edge
        load     = (mem_cnt != '0) && (!head_valid || pop_eff);
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                head_data  <= mem[rd_ptr];
                head_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end else if (pop_eff) begin
                head_valid <= 1'b0;
            end
            level <= level + LW'(push_eff) - LW'(pop_eff);
        end
    end

endmodule

// File: rtl/ft60x_fifo_bus_bfm.sv
// ft60x_fifo_bus_bfm
//   Device-side model of an FT600/FT601/FT245-style synchronous FIFO bus.
//   Per channel it keeps an RX FIFO (host preload -> bus read) and a TX FIFO
//   (bus write -> host pop), drives rxf_n/txe_n from occupancy, runs a bus
//   FSM with OE#-to-data turnaround and records sticky protocol errors.
//   Optional macro FT60X_BFM_STALL_EN adds LFSR-driven flag stalls.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   data, be                   bidirectional bus, driven only in RD with oe_n low
//   oe_n, rd_n, wr_n           FT strobes (active low)
//   rxf_n, txe_n               per-channel readable / writable flags
//   rd_ch_sel, wr_ch_sel       bus channel for reads / writes
//   rx_host_wr_*               host preload of RX FIFOs (+ ready)
//   tx_host_rd_*               host pop of TX FIFOs, registered result
//   rx_level, tx_level         per-channel occupancy, channel 0 in LSBs
//   bus_state                  FSM state
//   proto_err, err_clr         sticky error bits and synchronous clear
//
// state | meaning
// IDLE  | bus released, waiting for oe_n or wr_n
// TURN  | oe_n seen, waiting RD_TURN_CYC cycles before driving
// RD    | device drives RX head of rd_ch_sel while oe_n is low
// WR    | host drives data, words pushed into TX FIFO of wr_ch_sel
module ft60x_fifo_bus_bfm
    import ft60x_bfm_pkg::*;
#(
    parameter  int          DATA_WIDTH    = 32,
    parameter  int          NUM_CH        = 4,
    parameter  int          FIFO_DEPTH    = 512,
    parameter  int          USE_BE        = 1,
    parameter  int          RD_TURN_CYC   = 1,
    parameter  int          TXE_MIN_SPACE = 1,
    parameter  logic [15:0] STALL_SEED    = 16'hACE1,
    localparam int          BE_W          = DATA_WIDTH / 8,
    localparam int          CH_W          = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
    localparam int          LW            = clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire logic [DATA_WIDTH-1:0] data,
    inout  wire logic [BE_W-1:0]   be,
    input  logic                   oe_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    output logic [NUM_CH-1:0]      rxf_n,
    output logic [NUM_CH-1:0]      txe_n,
    input  logic [CH_W-1:0]        rd_ch_sel,
    input  logic [CH_W-1:0]        wr_ch_sel,
    input  logic                   rx_host_wr_en,
    input  logic [CH_W-1:0]        rx_host_wr_ch,
    input  logic [DATA_WIDTH-1:0]  rx_host_wr_data,
    input  logic [BE_W-1:0]        rx_host_wr_be,
    output logic                   rx_host_wr_ready,
    input  logic                   tx_host_rd_en,
    input  logic [CH_W-1:0]        tx_host_rd_ch,
    output logic                   tx_host_rd_valid,
    output logic [DATA_WIDTH-1:0]  tx_host_rd_data,
    output logic [BE_W-1:0]        tx_host_rd_be,
    output logic [NUM_CH*LW-1:0]   rx_level,
    output logic [NUM_CH*LW-1:0]   tx_level,
    output logic [1:0]             bus_state,
    output logic [3:0]             proto_err,
    input  logic                   err_clr
);

    localparam int          FW          = DATA_WIDTH + BE_W;
    localparam logic [1:0]  TURN_LOAD   = 2'((RD_TURN_CYC > 0) ? RD_TURN_CYC - 1 : 0);
    // txe_n low while free space >= TXE_MIN_SPACE, i.e. level <= this bound
    localparam logic [LW-1:0] TXE_MAX_LVL = LW'(FIFO_DEPTH - TXE_MIN_SPACE);

    bus_state_t        state;
    bus_state_t        state_nxt;
    logic [1:0]        turn_cnt;
    logic [1:0]        turn_cnt_nxt;
    logic              init_done;
    logic              stall;

    logic [NUM_CH-1:0] rx_push, rx_pop, rx_head_valid, rx_full;
    logic [NUM_CH-1:0] tx_push, tx_pop, tx_head_valid, tx_full;
    logic [NUM_CH-1:0] txe_occ_n;
    logic [FW-1:0]     rx_head [NUM_CH];
    logic [FW-1:0]     tx_head [NUM_CH];
    logic [LW-1:0]     rx_lvl  [NUM_CH];
    logic [LW-1:0]     tx_lvl  [NUM_CH];

    logic [FW-1:0]     rx_host_word;
    logic [FW-1:0]     bus_wr_word;
    logic [FW-1:0]     drive_word;
    logic              drive_en;
    logic              bus_rd_pop;
    logic              bus_wr_push;

    logic [CH_W-1:0]   rd_ch_q;
    logic [CH_W-1:0]   wr_ch_q;
    logic [3:0]        err_set;

    // ---------------- stall source ----------------
`ifdef FT60X_BFM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= STALL_SEED;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign stall = (lfsr[2:0] == 3'd0);
`else
    assign stall = 1'b0;
`endif

    // txe_n stays high for the reset cycle itself, low from the first edge after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) init_done <= 1'b0;
        else     init_done <= 1'b1;
    end

    // ---------------- channel FIFOs ----------------
    assign rx_host_word = {(USE_BE != 0) ? rx_host_wr_be : {BE_W{1'b1}}, rx_host_wr_data};
    assign bus_wr_word  = {(USE_BE != 0) ? be : {BE_W{1'b1}}, data};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ft60x_fwft_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (rx_push[g]),
            .push_data  (rx_host_word),
            .pop        (rx_pop[g]),
            .head_valid (rx_head_valid[g]),
            .head_data  (rx_head[g]),
            .level      (rx_lvl[g]),
            .full       (rx_full[g])
        );

        ft60x_fwft_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (tx_push[g]),
            .push_data  (bus_wr_word),
            .pop        (tx_pop[g]),
            .head_valid (tx_head_valid[g]),
            .head_data  (tx_head[g]),
            .level      (tx_lvl[g]),
            .full       (tx_full[g])
        );

        assign rx_push[g] = rx_host_wr_en && (rx_host_wr_ch == CH_W'(g)) && !rx_full[g];
        assign rx_pop[g]  = bus_rd_pop && (rd_ch_sel == CH_W'(g));
        assign tx_push[g] = bus_wr_push && (wr_ch_sel == CH_W'(g)) && !tx_full[g];
        assign tx_pop[g]  = tx_host_rd_en && (tx_host_rd_ch == CH_W'(g)) && tx_head_valid[g];

        assign txe_occ_n[g] = !(init_done && (tx_lvl[g] <= TXE_MAX_LVL));
        assign rxf_n[g]     = !rx_head_valid[g] || stall;
        assign txe_n[g]     = txe_occ_n[g] || stall;

        assign rx_level[g*LW +: LW] = rx_lvl[g];
        assign tx_level[g*LW +: LW] = tx_lvl[g];
    end

    assign rx_host_wr_ready = !rx_full[rx_host_wr_ch];

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            turn_cnt <= '0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        case (state)
            ST_IDLE: begin
                if (!wr_n && oe_n) begin
                    state_nxt = ST_WR;
                end else if (!oe_n && wr_n) begin
                    if (RD_TURN_CYC == 0) begin
                        state_nxt = ST_RD;
                    end else begin
                        state_nxt    = ST_TURN;
                        turn_cnt_nxt = TURN_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (oe_n)                 state_nxt = ST_IDLE;
                else if (turn_cnt == '0)  state_nxt = ST_RD;
                else                      turn_cnt_nxt = turn_cnt - 2'd1;
            end
            ST_RD:   if (oe_n) state_nxt = ST_IDLE;
            ST_WR:   if (wr_n) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_state   = state;
        drive_en    = (state == ST_RD) && !oe_n;
        drive_word  = rx_head_valid[rd_ch_sel] ? rx_head[rd_ch_sel] : '0;
        bus_rd_pop  = (state == ST_RD) && !rd_n && rx_head_valid[rd_ch_sel] && !stall;
        bus_wr_push = (state == ST_WR) && !wr_n && !txe_occ_n[wr_ch_sel] && !stall;
    end

    assign data = drive_en ? drive_word[DATA_WIDTH-1:0] : 'z;
    assign be   = drive_en ? drive_word[FW-1:DATA_WIDTH] : 'z;

    // ---------------- host TX pop ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_host_rd_valid <= 1'b0;
            tx_host_rd_data  <= '0;
            tx_host_rd_be    <= '0;
        end else begin
            tx_host_rd_valid <= |tx_pop;
            if (|tx_pop) {tx_host_rd_be, tx_host_rd_data} <= tx_head[tx_host_rd_ch];
        end
    end

    // ---------------- protocol errors ----------------
    // Error detection uses the occupancy flag, so stall-masked strobes are not errors.
    always_comb begin
        err_set                  = '0;
        err_set[ERR_OE_WR]       = !oe_n && !wr_n;
        err_set[ERR_RD_OUTSIDE]  = !rd_n && (state != ST_RD);
        err_set[ERR_WR_NO_SPACE] = !wr_n && txe_occ_n[wr_ch_sel];
        err_set[ERR_CH_CHANGE]   = ((state == ST_RD) && (rd_ch_sel != rd_ch_q)) ||
                                   ((state == ST_WR) && (wr_ch_sel != wr_ch_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ch_q   <= '0;
            wr_ch_q   <= '0;
            proto_err <= '0;
        end else begin
            rd_ch_q <= rd_ch_sel;
            wr_ch_q <= wr_ch_sel;
            if (err_clr) proto_err <= '0;
            else         proto_err <= proto_err | err_set;
        end
    end

endmodule

// File: tb/tb_ft60x_fifo_bus_bfm.sv
module tb_ft60x_fifo_bus_bfm;

    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int TMS   = 4;
    localparam int LW    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] data;
    wire  [3:0]  be;
    logic [31:0] tb_data = '0;
    logic [3:0]  tb_be   = '0;
    logic        tb_den  = 1'b0;
    logic        oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [3:0]  rxf_n, txe_n;
    logic [1:0]  rd_ch_sel = '0, wr_ch_sel = '0;
    logic        rx_host_wr_en = 1'b0;
    logic [1:0]  rx_host_wr_ch = '0;
    logic [31:0] rx_host_wr_data = '0;
    logic [3:0]  rx_host_wr_be = '0;
    logic        rx_host_wr_ready;
    logic        tx_host_rd_en = 1'b0;
    logic [1:0]  tx_host_rd_ch = '0;
    logic        tx_host_rd_valid;
    logic [31:0] tx_host_rd_data;
    logic [3:0]  tx_host_rd_be;
    logic [NCH*LW-1:0] rx_level, tx_level;
    logic [1:0]  bus_state;
    logic [3:0]  proto_err;
    logic        err_clr = 1'b0;

    assign data = tb_den ? tb_data : 'z;
    assign be   = tb_den ? tb_be   : 'z;

    always #5 clk = ~clk;

    ft60x_fifo_bus_bfm #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .USE_BE(1),
        .RD_TURN_CYC(1), .TXE_MIN_SPACE(TMS), .STALL_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .be(be),
        .oe_n(oe_n), .rd_n(rd_n), .wr_n(wr_n),
        .rxf_n(rxf_n), .txe_n(txe_n),
        .rd_ch_sel(rd_ch_sel), .wr_ch_sel(wr_ch_sel),
        .rx_host_wr_en(rx_host_wr_en), .rx_host_wr_ch(rx_host_wr_ch),
        .rx_host_wr_data(rx_host_wr_data), .rx_host_wr_be(rx_host_wr_be),
        .rx_host_wr_ready(rx_host_wr_ready),
        .tx_host_rd_en(tx_host_rd_en), .tx_host_rd_ch(tx_host_rd_ch),
        .tx_host_rd_valid(tx_host_rd_valid), .tx_host_rd_data(tx_host_rd_data),
        .tx_host_rd_be(tx_host_rd_be),
        .rx_level(rx_level), .tx_level(tx_level),
        .bus_state(bus_state), .proto_err(proto_err), .err_clr(err_clr)
    );

    // Reference model: plain per-channel queues of {be, data}
    logic [35:0] rx_m [NCH][$];
    logic [35:0] tx_m [NCH][$];
    logic [35:0] exp_rd_q [$];
    logic [35:0] exp_tx_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rxl(input int ch);
        return 64'(rx_level[ch*LW +: LW]);
    endfunction

    function automatic logic [63:0] txl(input int ch);
        return 64'(tx_level[ch*LW +: LW]);
    endfunction

    // Monitor: compare every beat the DUT hands out against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus_state == 2'd2 && !oe_n && !rd_n && !rxf_n[rd_ch_sel]) begin
            if (exp_rd_q.size() == 0) check("rd_unexpected_beat", 64'(exp_rd_q.size()), 64'd1);
            else                      check("rd_word", 64'({be, data}), 64'(exp_rd_q.pop_front()));
        end
        if (!rst && tx_host_rd_valid) begin
            if (exp_tx_q.size() == 0) check("tx_unexpected_pop", 64'(exp_tx_q.size()), 64'd1);
            else check("tx_word", 64'({tx_host_rd_be, tx_host_rd_data}), 64'(exp_tx_q.pop_front()));
        end
    end

    task automatic host_push(input int ch, input logic [31:0] d, input logic [3:0] b);
        rx_host_wr_en   = 1'b1;
        rx_host_wr_ch   = ch[1:0];
        rx_host_wr_data = d;
        rx_host_wr_be   = b;
        #1;
        check("rx_wr_ready", 64'(rx_host_wr_ready), 64'(rx_m[ch].size() < DEPTH));
        if (rx_m[ch].size() < DEPTH) rx_m[ch].push_back({b, d});
        tick();
        rx_host_wr_en = 1'b0;
        check("rx_level_push", rxl(ch), 64'(rx_m[ch].size()));
    endtask

    task automatic bus_read(input int ch, input int n);
        rd_ch_sel = ch[1:0];
        oe_n = 1'b0;
        tick();
        check("turn_state", 64'(bus_state), 64'd1);
        tick();
        check("rd_state", 64'(bus_state), 64'd2);
        if (rx_m[ch].size() > 0) check("rd_head", 64'({be, data}), 64'(rx_m[ch][0]));
        for (int i = 0; i < n; i++) begin
            rd_n = 1'b0;
            exp_rd_q.push_back(rx_m[ch].pop_front());
            tick();
            check("rx_level_rd", rxl(ch), 64'(rx_m[ch].size()));
        end
        rd_n = 1'b1;
        check("rxf_after_rd", 64'(rxf_n[ch]), 64'(rx_m[ch].size() == 0));
        if (rx_m[ch].size() == 0) check("rd_empty_drive", 64'({be, data}), 64'd0);
        oe_n = 1'b1;
        tick();
        check("rd_done_state", 64'(bus_state), 64'd0);
        check("proto_err_rd", 64'(proto_err), 64'd0);
    endtask

    task automatic bus_write(input int ch, input int n, input logic [31:0] w0);
        bit dropped;
        dropped   = 1'b0;
        wr_ch_sel = ch[1:0];
        wr_n      = 1'b0;
        tb_den    = 1'b1;
        tb_data   = $urandom;
        tb_be     = 4'($urandom);
        tick();
        for (int i = 0; i < n; i++) begin
            tb_data = (i == 0) ? w0 : $urandom;
            tb_be   = (i == 0) ? 4'hF : 4'($urandom);
            if (DEPTH - tx_m[ch].size() >= TMS) tx_m[ch].push_back({tb_be, tb_data});
            else dropped = 1'b1;
            tick();
            check("tx_level_wr", txl(ch), 64'(tx_m[ch].size()));
            check("txe_n_wr", 64'(txe_n[ch]), 64'(DEPTH - tx_m[ch].size() < TMS));
        end
        wr_n   = 1'b1;
        tb_den = 1'b0;
        tick();
        check("proto_err_wr", 64'(proto_err), dropped ? 64'h4 : 64'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic host_pop(input int ch);
        bit had;
        tx_host_rd_en = 1'b1;
        tx_host_rd_ch = ch[1:0];
        had = (tx_m[ch].size() > 0);
        if (had) exp_tx_q.push_back(tx_m[ch].pop_front());
        tick();
        tx_host_rd_en = 1'b0;
        check("tx_valid", 64'(tx_host_rd_valid), 64'(had));
        check("tx_level_pop", txl(ch), 64'(tx_m[ch].size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ch, n;
        // ---------------- reset ----------------
        repeat (3) tick();
        check("rst_rxf_n", 64'(rxf_n), 64'hF);
        check("rst_txe_n", 64'(txe_n), 64'hF);
        check("rst_state", 64'(bus_state), 64'd0);
        check("rst_err", 64'(proto_err), 64'd0);
        check("rst_levels", 64'({rx_level, tx_level}), 64'd0);
        check("rst_tx_valid", 64'(tx_host_rd_valid), 64'd0);
        rst = 1'b0;
        tick();
        check("txe_after_rst", 64'(txe_n), 64'h0);

        // ---------------- single word ch2 ----------------
        host_push(2, 32'h11223344, 4'hF);
        check("rxf_not_yet", 64'(rxf_n[2]), 64'd1);
        tick();
        check("rxf_fwft", 64'(rxf_n[2]), 64'd0);
        bus_read(2, 1);

        // ---------------- 8-word burst ch0 ----------------
        for (int i = 0; i < 8; i++) host_push(0, $urandom, 4'($urandom));
        tick();
        bus_read(0, 8);

        // ---------------- RX full boundary ch3 ----------------
        for (int i = 0; i < DEPTH + 1; i++) host_push(3, $urandom, 4'($urandom));
        check("rx_full_level", rxl(3), 64'(DEPTH));
        bus_read(3, DEPTH);

        // ---------------- random RX rounds ----------------
        for (int r = 0; r < 6; r++) begin
            ch = $urandom_range(0, 3);
            n  = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) host_push(ch, $urandom, 4'($urandom));
            bus_read(ch, rx_m[ch].size());
        end

        // ---------------- TXE threshold ch1 ----------------
        bus_write(1, 14, $urandom);
        check("tx_thresh_level", txl(1), 64'(DEPTH - TMS + 1));
        for (int i = 0; i < DEPTH - TMS + 1; i++) host_pop(1);
        host_pop(1);

        // ---------------- DEADBEEF ch3 ----------------
        bus_write(3, 1, 32'hDEADBEEF);
        host_pop(3);
        tick();
        check("tx_valid_one_cycle", 64'(tx_host_rd_valid), 64'd0);

        // ---------------- random TX rounds ----------------
        for (int r = 0; r < 4; r++) begin
            ch = $urandom_range(0, 3);
            n  = $urandom_range(1, 5);
            bus_write(ch, n, $urandom);
            for (int i = 0; i < n; i++) host_pop(ch);
            host_pop(ch);
        end

        // ---------------- protocol errors ----------------
        wr_ch_sel = 2'd0;
        oe_n = 1'b0; wr_n = 1'b0;
        tick();
        oe_n = 1'b1; wr_n = 1'b1;
        check("err_oe_wr", 64'(proto_err), 64'h1);
        check("err_oe_wr_state", 64'(bus_state), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 64'(proto_err), 64'h0);
        rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        check("err_rd_outside", 64'(proto_err), 64'h2);
        rd_n = 1'b0; err_clr = 1'b1;
        tick();
        rd_n = 1'b1; err_clr = 1'b0;
        check("err_clr_wins", 64'(proto_err), 64'h0);
        host_push(1, $urandom, 4'hF);
        host_push(1, $urandom, 4'hF);
        rd_ch_sel = 2'd1; oe_n = 1'b0;
        tick(); tick();
        rd_ch_sel = 2'd2;
        tick();
        check("err_ch_change", 64'(proto_err), 64'h8);
        rd_ch_sel = 2'd1; oe_n = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        bus_read(1, 2);

        // ---------------- reset mid-read ----------------
        for (int i = 0; i < 4; i++) host_push(0, $urandom | 32'h1, 4'hF);
        rd_ch_sel = 2'd0; oe_n = 1'b0;
        tick(); tick();
        rd_n = 1'b0;
        exp_rd_q.push_back(rx_m[0].pop_front());
        tick();
        rd_n = 1'b1;
        rst  = 1'b1;
        #1;
        tb_data = '0; tb_be = '0; tb_den = 1'b1;
        #1;
        check("rst_bus_released", 64'({be, data}), 64'd0);
        check("rst_mid_state", 64'(bus_state), 64'd0);
        check("rst_mid_levels", 64'({rx_level, tx_level}), 64'd0);
        check("rst_mid_rxf", 64'(rxf_n), 64'hF);
        for (int c = 0; c < NCH; c++) begin
            rx_m[c].delete();
            tx_m[c].delete();
        end
        oe_n = 1'b1; tb_den = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("txe_after_rst2", 64'(txe_n), 64'h0);

        tick();
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
        check("tx_queue_drained", 64'(exp_tx_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
